dmem_sized: RTL
===============

# dmem_sized

Parametrised, byte-addressable data memory for the synapse32 load/store path. It supports the full set of RISC-V RV32I load and store widths (byte, halfword, word, with sign or zero extension), independent read and write ports, and one-cycle registered reads. It also detects misaligned, out-of-range and illegal accesses. It is the next-generation replacement for the fixed word-only `dmem` and sits between the MEM stage and the bus.

## Interface
Parameters:
- `DEPTH` (default 1024): number of 32-bit words; must be a power of two, at least 4.
- `BASE_ADDR` (default 32'h0000_0000): byte address of word 0; must be word-aligned.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `rd_en` in 1: load request this cycle.
- `rd_addr` in 32: load byte address.
- `rd_funct3` in 3: load type. 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- `wr_en` in 1: store request this cycle.
- `wr_addr` in 32: store byte address.
- `wr_funct3` in 3: store type. 000 SB, 001 SH, 010 SW.
- `wr_data` in 32: store data; the value sits in the low bits regardless of address offset.
- `rd_data` out 32: extended load result, registered.
- `rd_valid` out 1: `rd_data` is valid; one-cycle pulse.
- `fault_misaligned` out 1: the previous-cycle access was misaligned.
- `fault_range` out 1: the previous-cycle access was outside the memory.
- `fault_funct3` out 1: the previous-cycle access used an unsupported funct3.

## Operation
Address decoding:
- Offset is `addr - BASE_ADDR`, modulo 2^32.
- Word index is `offset[31:2]`; byte lane is `offset[1:0]`.
- An access is out of range if the word index is `DEPTH` or greater.

Checks, in priority order, applied to each port independently:
- Illegal funct3: load funct3 011/110/111, or store funct3 not 000/001/010.
- Misaligned: halfword access with `offset[0]`=1, or word access with `offset[1:0]`≠0.
- Out of range.

Suppression:
- Any faulting access is suppressed. Memory is unchanged and the load returns 0.
- Only the highest-priority fault flag is raised for that port.
- Fault flags from the two ports are ORed.

Stores:
- Writes only the addressed lanes.
- SB writes `wr_data[7:0]` to lane `offset[1:0]`.
- SH writes `wr_data[15:0]` to lanes {1,0} or {3,2}.
- SW writes all four lanes.

Loads:
- Selects the addressed byte or halfword.
- LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW returns the word as is.

Other rules:
- Memory contents are not cleared by `rst`; their power-up value is undefined.
- Simultaneous load and store to different words are fully independent.
- Load and store to the same word in the same cycle: read-first (load returns the pre-store value) unless `DMEM_BYPASS_EN` is set.

## Timing
- Store latency: the memory is updated at the edge where `wr_en`=1. A load issued the next cycle observes it.
- Load latency: 1 cycle. Request at edge N gives `rd_data` and `rd_valid` during cycle N+1.
- `rd_valid`=1 for exactly one cycle per load request, including faulting loads, for which `rd_data`=0.
- When `rd_en`=0, `rd_data` holds its last value and `rd_valid`=0.
- Fault flags are registered and assert in cycle N+1 for one cycle.
- Reset values: `rd_data`=0, `rd_valid`=0, all fault flags 0.
- Reset mid-operation: while `rst`=1 at an edge, any store at that edge is suppressed, no load is accepted, and all outputs return to their reset values. A load issued the cycle before reset produces no `rd_valid`.
- Back-to-back loads every cycle are supported at full throughput.

## Configuration
- `DMEM_BYPASS_EN` defined: a same-cycle load and store to the same word returns the store-merged word. New bytes appear in the written lanes and old bytes elsewhere, then the usual extension is applied. The bypass applies only if the store itself did not fault.
- `DMEM_BYPASS_EN` undefined: read-first behaviour; no comparator or merge logic is instantiated.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `rd_en`=1 → `rd_data`=0, `rd_valid`=0, flags 0; a store issued under reset leaves memory unchanged.
- Width and extension: SW 0x8081_F0FF at 0x10, then loads next cycle:
  - LB 0x10 → 0xFFFF_FFFF.
  - LBU 0x11 → 0x0000_00F0.
  - LH 0x12 → 0xFFFF_8081.
  - LHU 0x12 → 0x0000_8081.
  - LW 0x10 → 0x8081_F0FF.
- Partial stores: SB 0xAA at 0x21, then SH 0x1234 at 0x22, over a word previously holding 0 → LW 0x20 returns 0x1234_AA00.
- Faults:
  - LH at 0x13 → `fault_misaligned`=1, `rd_valid`=1, `rd_data`=0.
  - SW at byte address `BASE_ADDR+4*DEPTH` → `fault_range`=1, no write.
  - Load with funct3 011 → `fault_funct3`=1.
- Same-word collision: SW 0x1111_1111 at 0x30 first, then SB 0x22 at 0x30 together with LW 0x30 → returns 0x1111_1111 without `DMEM_BYPASS_EN`, 0x1111_1122 with it; a following LW 0x30 returns 0x1111_1122 in both builds.
- Throughput: 8 consecutive loads on consecutive cycles → 8 consecutive `rd_valid` pulses with in-order data.

Source files
------------

// File: rtl/dmem_sized.sv
// Byte-addressable data memory with RV32I load/store widths, one-cycle registered reads
// and fault detection. Optional same-word store-to-load forwarding under `DMEM_BYPASS_EN`.
module dmem_sized #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic [31:0] rd_addr,
    input  logic [2:0]  rd_funct3,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [2:0]  wr_funct3,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        fault_misaligned,
    output logic        fault_range,
    output logic        fault_funct3
);

    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef struct packed {
        logic f3;
        logic mis;
        logic rng;
    } fault_t;

    // Faults are mutually exclusive: only the highest-priority one is reported.
    function automatic fault_t classify(input logic [31:0] off, input logic [2:0] f3,
                                        input logic f3_legal);
        fault_t f;
        f.f3  = !f3_legal;
        f.mis = f3_legal && ((f3[1:0] == 2'b01 && off[0]) ||
                             (f3[1:0] == 2'b10 && off[1:0] != 2'b00));
        f.rng = f3_legal && !f.mis && ({2'b00, off[31:2]} >= 32'(DEPTH));
        return f;
    endfunction

    logic [31:0] mem_q [DEPTH];

    logic [31:0] rd_off, wr_off;
    logic [AW-1:0] rd_idx, wr_idx;
    fault_t      rd_flt, wr_flt;
    logic        rd_ok, wr_ok;
    logic [3:0]  wr_be;
    logic [31:0] wr_lanes;
    logic [31:0] rd_word;
    logic [31:0] rd_shifted;
    logic [31:0] rd_ext;

    logic [31:0] rd_data_d, rd_data_q;
    logic        rd_valid_d, rd_valid_q;
    fault_t      fault_d, fault_q;

    assign rd_off = rd_addr - BASE_ADDR;
    assign wr_off = wr_addr - BASE_ADDR;
    assign rd_idx = rd_off[AW+1:2];
    assign wr_idx = wr_off[AW+1:2];

    assign rd_flt = classify(rd_off, rd_funct3,
                             rd_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    assign wr_flt = classify(wr_off, wr_funct3, wr_funct3 inside {F3_B, F3_H, F3_W});
    assign rd_ok  = rd_flt == '0;
    assign wr_ok  = wr_flt == '0;

    // Store data is replicated across lanes so each byte enable picks the right slice.
    // NOTE: every signal assigned in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        wr_be    = 4'b0000;
        wr_lanes = wr_data;
        unique case (wr_funct3[1:0])
            2'b00: begin
                wr_be    = 4'b0001 << wr_off[1:0];
                wr_lanes = {4{wr_data[7:0]}};
            end
            2'b01: begin
                wr_be    = wr_off[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{wr_data[15:0]}};
            end
            2'b10:   wr_be = 4'b1111;
            default: wr_be = 4'b0000;
        endcase
    end

`ifdef DMEM_BYPASS_EN
    logic        bypass_hit;
    logic [31:0] mem_word;

    assign bypass_hit = wr_en && wr_ok && rd_ok && (rd_idx == wr_idx);
    assign mem_word   = mem_q[rd_idx];

    always_comb begin
        rd_word = mem_word;
        for (int i = 0; i < 4; i++) begin
            if (bypass_hit && wr_be[i]) begin
                rd_word[8*i +: 8] = wr_lanes[8*i +: 8];
            end
        end
    end
`else
    // Read-first: the array read sees the value from before this edge's store.
    assign rd_word = mem_q[rd_idx];
`endif

    assign rd_shifted = rd_word >> {rd_off[1:0], 3'b000};

    always_comb begin
        rd_ext = rd_shifted;
        unique case (rd_funct3)
            F3_B:    rd_ext = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            F3_H:    rd_ext = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            F3_BU:   rd_ext = {24'h0, rd_shifted[7:0]};
            F3_HU:   rd_ext = {16'h0, rd_shifted[15:0]};
            default: rd_ext = rd_shifted;
        endcase
    end

    always_comb begin
        rd_valid_d = rd_en;
        rd_data_d  = rd_data_q;
        if (rd_en) begin
            rd_data_d = rd_ok ? rd_ext : 32'h0;
        end
        fault_d = (rd_en ? rd_flt : fault_t'('0)) | (wr_en ? wr_flt : fault_t'('0));
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= 32'h0;
            rd_valid_q <= 1'b0;
            fault_q    <= '0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            fault_q    <= fault_d;
        end
    end

    // NOTE: the storage array has no reset; clearing it would force it out of RAM into flops.
    always_ff @(posedge clk) begin
        if (!rst && wr_en && wr_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem_q[wr_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
                end
            end
        end
    end

    assign rd_data          = rd_data_q;
    assign rd_valid         = rd_valid_q;
    assign fault_misaligned = fault_q.mis;
    assign fault_range      = fault_q.rng;
    assign fault_funct3     = fault_q.f3;

endmodule
